// File: rtl/fakeram_pkg.sv
// Shared types, latency limits and lane helper for the fakeram 1RW1R SRAM model.
package fakeram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } read_mode_e;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 2;

    // Lowest bit position covered by write-mask lane `lane`.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned gran);
        return lane * gran;
    endfunction

endpackage

// File: rtl/fakeram_1rw1r_param_sram_if.sv
// Request/response bundle for the fakeram 1RW1R SRAM: one read port (r0), one read/write port (rw0).
interface fakeram_1rw1r_param_sram_if #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned MASK_GRAN  = 8
);
    logic                        r0_ce_in;
    logic [ADDR_WIDTH-1:0]       r0_addr_in;
    logic [BITS-1:0]             r0_rd_out;
    logic                        r0_valid_out;

    logic                        rw0_ce_in;
    logic                        rw0_we_in;
    logic [BITS/MASK_GRAN-1:0]   rw0_wmask_in;
    logic [ADDR_WIDTH-1:0]       rw0_addr_in;
    logic [BITS-1:0]             rw0_wd_in;
    logic [BITS-1:0]             rw0_rd_out;
    logic                        rw0_valid_out;

    logic                        collision_out;
    logic                        oob_err_out;

    modport master (
        output r0_ce_in, r0_addr_in,
        output rw0_ce_in, rw0_we_in, rw0_wmask_in, rw0_addr_in, rw0_wd_in,
        input  r0_rd_out, r0_valid_out, rw0_rd_out, rw0_valid_out,
        input  collision_out, oob_err_out
    );

    modport slave (
        input  r0_ce_in, r0_addr_in,
        input  rw0_ce_in, rw0_we_in, rw0_wmask_in, rw0_addr_in, rw0_wd_in,
        output r0_rd_out, r0_valid_out, rw0_rd_out, rw0_valid_out,
        output collision_out, oob_err_out
    );

endinterface

// File: rtl/fakeram_rd_pipe.sv
// Extra read-latency stages: data, valid and one side flag advance together every clock.
module fakeram_rd_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_flag,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_flag
);

    if (DEPTH == 0) begin : g_bypass
        assign o_data  = i_data;
        assign o_valid = i_valid;
        assign o_flag  = i_flag;
    end else begin : g_stages
        logic [WIDTH-1:0] r_data  [DEPTH];
        logic [DEPTH-1:0] r_valid;
        logic [DEPTH-1:0] r_flag;

        // No enable: a held first-stage word simply re-propagates.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_data[k] <= '0;
                end
                r_valid <= '0;
                r_flag  <= '0;
            end else begin
                r_data[0]  <= i_data;
                r_valid[0] <= i_valid;
                r_flag[0]  <= i_flag;
                for (int k = 1; k < DEPTH; k++) begin
                    r_data[k]  <= r_data[k-1];
                    r_valid[k] <= r_valid[k-1];
                    r_flag[k]  <= r_flag[k-1];
                end
            end
        end

        assign o_data  = r_data[DEPTH-1];
        assign o_valid = r_valid[DEPTH-1];
        assign o_flag  = r_flag[DEPTH-1];
    end

endmodule

// File: rtl/fakeram_1rw1r_param_sram.sv
// Behavioural 1RW1R SRAM with byte-lane masking, collision flag and sticky out-of-range error.
// Optional X-corruption checking on rw0 controls is enabled by defining FAKERAM_X_CORRUPT_EN.
module fakeram_1rw1r_param_sram #(
    parameter int unsigned BITS         = 32,
    parameter int unsigned WORD_DEPTH   = 384,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned MASK_GRAN    = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_FIRST  = 0
) (
    input logic                         clk,
    input logic                         rst,
    fakeram_1rw1r_param_sram_if.slave   bus
);
    // Explicit imports: the package enumerator WRITE_FIRST shares a name with the parameter.
    import fakeram_pkg::read_mode_e;
    import fakeram_pkg::lane_lsb;
    import fakeram_pkg::LAT_MIN;
    import fakeram_pkg::LAT_MAX;

    localparam int unsigned Lanes = BITS / MASK_GRAN;
    localparam read_mode_e ReadMode = read_mode_e'(WRITE_FIRST != 0);
    localparam logic [ADDR_WIDTH:0] DepthLimit = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    if (BITS % MASK_GRAN != 0) begin : g_bad_gran
        $error("BITS must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if ((64'd1 << ADDR_WIDTH) < 64'(WORD_DEPTH)) begin : g_bad_aw
        $error("ADDR_WIDTH too small for WORD_DEPTH");
    end

    logic [BITS-1:0] r_mem [WORD_DEPTH];

    logic            w_r0_in_range;
    logic            w_rw0_in_range;
    logic            w_wr_en;
    logic            w_wr_hit;
    logic            w_r0_coll;
    logic [BITS-1:0] w_rw0_old;
    logic [BITS-1:0] w_r0_old;
    logic [BITS-1:0] w_merged;
    logic [BITS-1:0] w_rw0_rd;
    logic [BITS-1:0] w_r0_rd;

    logic [BITS-1:0] r_r0_data;
    logic            r_r0_valid;
    logic            r_r0_coll;
    logic [BITS-1:0] r_rw0_data;
    logic            r_rw0_valid;
    logic            r_oob;

    logic            w_unused_rw0_flag;

    assign w_r0_in_range  = {1'b0, bus.r0_addr_in} < DepthLimit;
    assign w_rw0_in_range = {1'b0, bus.rw0_addr_in} < DepthLimit;

    assign w_wr_en  = !rst && bus.rw0_ce_in && bus.rw0_we_in && w_rw0_in_range;
    assign w_wr_hit = w_wr_en && (|bus.rw0_wmask_in);
    assign w_r0_coll = bus.r0_ce_in && w_r0_in_range && w_wr_hit
                       && (bus.r0_addr_in == bus.rw0_addr_in);

    assign w_rw0_old = w_rw0_in_range ? r_mem[bus.rw0_addr_in] : '0;
    assign w_r0_old  = w_r0_in_range  ? r_mem[bus.r0_addr_in]  : '0;

    always_comb begin
        w_merged = w_rw0_old;
        for (int unsigned l = 0; l < Lanes; l++) begin
            if (bus.rw0_wmask_in[l]) begin
                w_merged[lane_lsb(l, MASK_GRAN) +: MASK_GRAN] =
                    bus.rw0_wd_in[lane_lsb(l, MASK_GRAN) +: MASK_GRAN];
            end
        end
    end

    assign w_rw0_rd = (ReadMode == fakeram_pkg::WRITE_FIRST && w_wr_en) ? w_merged : w_rw0_old;

    // A colliding r0 read shares the rw0 word, so the rw0 merge is the write-first value.
    always_comb begin
        w_r0_rd = (ReadMode == fakeram_pkg::WRITE_FIRST && w_r0_coll) ? w_merged : w_r0_old;
`ifdef FAKERAM_X_CORRUPT_EN
        if (bus.r0_ce_in && $isunknown(bus.r0_addr_in)) begin
            w_r0_rd = 'x;
        end
`endif
    end

    // Storage has no reset; writes are gated off while rst is high through w_wr_en.
    always_ff @(posedge clk) begin
`ifdef FAKERAM_X_CORRUPT_EN
        if (!rst && bus.rw0_ce_in
            && $isunknown({bus.rw0_we_in, bus.rw0_addr_in, bus.rw0_wmask_in})) begin
            for (int i = 0; i < WORD_DEPTH; i++) begin
                r_mem[i] <= 'x;
            end
            $display("fakeram_1rw1r_param_sram: X on rw0 controls, we=%b addr=%h wmask=%b",
                     bus.rw0_we_in, bus.rw0_addr_in, bus.rw0_wmask_in);
        end else
`endif
        if (w_wr_en) begin
            r_mem[bus.rw0_addr_in] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r0_data   <= '0;
            r_r0_valid  <= 1'b0;
            r_r0_coll   <= 1'b0;
            r_rw0_data  <= '0;
            r_rw0_valid <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_r0_valid  <= bus.r0_ce_in;
            r_r0_coll   <= w_r0_coll;
            r_rw0_valid <= bus.rw0_ce_in;
            if (bus.r0_ce_in) begin
                r_r0_data <= w_r0_rd;
            end
            if (bus.rw0_ce_in) begin
                r_rw0_data <= w_rw0_rd;
            end
            if ((bus.r0_ce_in && !w_r0_in_range) || (bus.rw0_ce_in && !w_rw0_in_range)) begin
                r_oob <= 1'b1;
            end
        end
    end

    fakeram_rd_pipe #(
        .WIDTH (BITS),
        .DEPTH (READ_LATENCY - 1)
    ) u_r0_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_data  (r_r0_data),
        .i_valid (r_r0_valid),
        .i_flag  (r_r0_coll),
        .o_data  (bus.r0_rd_out),
        .o_valid (bus.r0_valid_out),
        .o_flag  (bus.collision_out)
    );

    fakeram_rd_pipe #(
        .WIDTH (BITS),
        .DEPTH (READ_LATENCY - 1)
    ) u_rw0_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_data  (r_rw0_data),
        .i_valid (r_rw0_valid),
        .i_flag  (1'b0),
        .o_data  (bus.rw0_rd_out),
        .o_valid (bus.rw0_valid_out),
        .o_flag  (w_unused_rw0_flag)
    );

    assign bus.oob_err_out = r_oob;

endmodule
